// File: rtl/data_mem_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_unit_pkg
// Purpose : Shared defaults for the data-memory stage: word width, RAM index
//           width, write-buffer depth and the buffer entry layout
//           {addr[ADDR_BITS-1:0], data[DATA_WIDTH-1:0]}.
// Ports   : none (package)
// Config  : DMEM_FORWARD_EN selects store-to-load forwarding (see top).
// Rev     : 1.0  initial release
// ============================================================================
package data_mem_unit_pkg;

  localparam int DMEM_DATA_WIDTH = 16;
  localparam int DMEM_ADDR_BITS  = 8;
  localparam int DMEM_WB_DEPTH   = 4;

  // Buffer entry with the default widths; kept as the reference layout.
  typedef struct packed {
    logic [DMEM_ADDR_BITS-1:0]  addr;
    logic [DMEM_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage : data_mem_unit_pkg
`default_nettype wire

// File: rtl/data_mem_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_unit_if
// Purpose : MEM-stage request/response bundle between pipeline and data memory.
// Ports   : MemRead, MemWrite, MemAddr, MemData   (pipeline -> memory)
//           MemOutput, MemStall, MemIdle          (memory -> pipeline)
// Config  : none
// Rev     : 1.0  initial release
// ============================================================================
interface data_mem_unit_if #(
  parameter int DATA_WIDTH = data_mem_unit_pkg::DMEM_DATA_WIDTH
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] MemAddr;
  logic [DATA_WIDTH-1:0] MemData;
  logic [DATA_WIDTH-1:0] MemOutput;
  logic                  MemStall;
  logic                  MemIdle;

  modport master (
    output MemRead, MemWrite, MemAddr, MemData,
    input  MemOutput, MemStall, MemIdle
  );

  modport slave (
    input  MemRead, MemWrite, MemAddr, MemData,
    output MemOutput, MemStall, MemIdle
  );
endinterface : data_mem_unit_if
`default_nettype wire

// File: rtl/dmem_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : dmem_wb_fifo
// Purpose : Circular posted-write buffer. Exposes every slot with its valid
//           bit and its age (0 = oldest) so the caller can find the youngest
//           entry matching a load address.
// Ports   : clk, rst_n          clock, async active-low reset
//           push/push_addr/push_data   enqueue at tail (caller ensures !full)
//           pop                 dequeue head (caller ensures !empty)
//           full, empty, count  occupancy 0..WB_DEPTH
//           head_addr/head_data oldest entry
//           entry_*             per-slot addr/data/valid/age
// Config  : none
// Rev     : 1.0  initial release
// ============================================================================
module dmem_wb_fifo
  import data_mem_unit_pkg::*;
#(
  parameter int ADDR_BITS  = DMEM_ADDR_BITS,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int WB_DEPTH   = DMEM_WB_DEPTH,
  parameter int PW         = $clog2(WB_DEPTH),
  parameter int CW         = $clog2(WB_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_BITS-1:0]  push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic [ADDR_BITS-1:0]  head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_BITS-1:0]  entry_addr  [WB_DEPTH],
  output logic [DATA_WIDTH-1:0] entry_data  [WB_DEPTH],
  output logic                  entry_valid [WB_DEPTH],
  output logic [PW-1:0]         entry_age   [WB_DEPTH]
);

  logic [ADDR_BITS-1:0]  r_addr [WB_DEPTH];
  logic [DATA_WIDTH-1:0] r_data [WB_DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  // Pointers wrap naturally because WB_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_tail <= r_tail + 1'b1;
      if (pop)  r_head <= r_head + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      r_addr[r_tail] <= push_addr;
      r_data[r_tail] <= push_data;
    end
  end

  assign full      = (r_count == CW'(WB_DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_addr = r_addr[r_head];
  assign head_data = r_data[r_head];

  generate
    for (genvar i = 0; i < WB_DEPTH; i++) begin : g_entry
      logic [PW-1:0] w_age;
      // Distance from the head: 0 is the oldest, count-1 the youngest.
      assign w_age          = PW'(i) - r_head;
      assign entry_age[i]   = w_age;
      assign entry_valid[i] = (CW'(w_age) < r_count);
      assign entry_addr[i]  = r_addr[i];
      assign entry_data[i]  = r_data[i];
    end
  endgenerate

endmodule : dmem_wb_fifo
`default_nettype wire

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_unit
// Purpose : MEM-stage data memory: single-port synchronous RAM fronted by a
//           posted-write buffer. Stores retire in one cycle; loads return one
//           cycle later on a registered output. Reads win the RAM port over
//           draining unless the buffer is full.
// Ports   : CLK     clock
//           RST_N   asynchronous active-low reset
//           mem     data_mem_unit_if.slave (MemRead/MemWrite/MemAddr/MemData
//                   in, MemOutput/MemStall/MemIdle out)
// Config  : DMEM_FORWARD_EN defined   -> loads hitting the buffer forward the
//                                        youngest matching entry.
//           DMEM_FORWARD_EN undefined -> loads hitting the buffer stall until
//                                        the matching entries have drained.
// Rev     : 1.0  initial release
// ============================================================================
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_BITS  = DMEM_ADDR_BITS,
  parameter int WB_DEPTH   = DMEM_WB_DEPTH
) (
  input  logic           CLK,
  input  logic           RST_N,
  data_mem_unit_if.slave mem
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = $clog2(WB_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_ram [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_idle;

  logic                  w_full, w_empty;
  logic [CW-1:0]         w_count;
  logic [ADDR_BITS-1:0]  w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [ADDR_BITS-1:0]  w_entry_addr  [WB_DEPTH];
  logic [DATA_WIDTH-1:0] w_entry_data  [WB_DEPTH];
  logic                  w_entry_valid [WB_DEPTH];
  logic [PW-1:0]         w_entry_age   [WB_DEPTH];

  logic [ADDR_BITS-1:0]  w_req_addr;
  logic                  w_load, w_stall, w_load_acc;
  logic                  w_hit, w_fwd_hit, w_hazard_stall;
  logic [DATA_WIDTH-1:0] w_hit_data;
  logic [PW-1:0]         w_hit_age;
  logic                  w_ram_rd, w_push, w_pop;

  // Upper address bits are ignored: addresses wrap modulo the RAM depth.
  assign w_req_addr = mem.MemAddr[ADDR_BITS-1:0];

  generate
    if (DATA_WIDTH > ADDR_BITS) begin : g_unused_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^mem.MemAddr[DATA_WIDTH-1:ADDR_BITS];
    end
  endgenerate

  // Youngest matching entry = valid match with the largest age.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_hit_age  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (w_entry_valid[i] && (w_entry_addr[i] == w_req_addr) &&
          (!w_hit || (w_entry_age[i] > w_hit_age))) begin
        w_hit      = 1'b1;
        w_hit_data = w_entry_data[i];
        w_hit_age  = w_entry_age[i];
      end
    end
  end

`ifdef DMEM_FORWARD_EN
  assign w_fwd_hit      = w_hit;
  assign w_hazard_stall = 1'b0;
`else
  assign w_fwd_hit      = 1'b0;
  assign w_hazard_stall = w_hit;
`endif

  // Both strobes high is a store only. A full buffer stalls loads too so
  // that draining gets the RAM port.
  assign w_load     = mem.MemRead & ~mem.MemWrite;
  assign w_stall    = mem.MemWrite ? w_full : (w_load & (w_full | w_hazard_stall));
  assign w_load_acc = w_load & ~w_stall;
  assign w_ram_rd   = w_load_acc & ~w_fwd_hit;
  assign w_pop      = ~w_empty & ~w_ram_rd;
  // Full is sampled before this cycle's pop: a pop never frees a same-cycle slot.
  assign w_push     = mem.MemWrite & ~w_full;

  dmem_wb_fifo #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH),
    .WB_DEPTH   (WB_DEPTH)
  ) u_wb_fifo (
    .clk         (CLK),
    .rst_n       (RST_N),
    .push        (w_push),
    .push_addr   (w_req_addr),
    .push_data   (mem.MemData),
    .pop         (w_pop),
    .full        (w_full),
    .empty       (w_empty),
    .count       (w_count),
    .head_addr   (w_head_addr),
    .head_data   (w_head_data),
    .entry_addr  (w_entry_addr),
    .entry_data  (w_entry_data),
    .entry_valid (w_entry_valid),
    .entry_age   (w_entry_age)
  );

  // RAM contents survive reset.
  always_ff @(posedge CLK) begin
    if (w_pop) r_ram[w_head_addr] <= w_head_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out  <= '0;
      r_idle <= 1'b1;
    end else begin
      if (w_load_acc) r_out <= w_fwd_hit ? w_hit_data : r_ram[w_req_addr];
      if (w_push)
        r_idle <= 1'b0;
      else if (w_pop && (w_count == CW'(1)))
        r_idle <= 1'b1;
    end
  end

  assign mem.MemOutput = r_out;
  assign mem.MemStall  = w_stall;
  assign mem.MemIdle   = r_idle;

endmodule : data_mem_unit
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_unit
// Purpose : Self-checking bench for data_mem_unit. A queue-based reference
//           model predicts stall/idle each cycle and pushes expected load
//           results into a scoreboard consumed by an independent monitor.
// Config  : honours DMEM_FORWARD_EN like the design.
// Rev     : 1.0  initial release
// ============================================================================
module tb_data_mem_unit;
  import data_mem_unit_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
`ifdef DMEM_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_unit_if #(.DATA_WIDTH(DW)) mif ();

  data_mem_unit dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .mem   (mif)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: RAM image with known flags plus an ordered store list.
  logic [DW-1:0] ref_mem   [2**AW];
  bit            ref_known [2**AW];
  logic [AW-1:0] wb_addr_q [$];
  logic [DW-1:0] wb_data_q [$];

  typedef struct {
    logic [DW-1:0] val;
    bit            known;
  } exp_t;
  exp_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One request cycle; entered and left at posedge+1.
  task automatic step(input bit rd, input bit wr, input logic [DW-1:0] addr,
                      input logic [DW-1:0] data, output bit stalled);
    logic [AW-1:0] a;
    bit            full, hit, exp_stall, ld_acc, ram_read;
    logic [DW-1:0] hit_val;
    mif.MemRead  = rd;
    mif.MemWrite = wr;
    mif.MemAddr  = addr;
    mif.MemData  = data;
    @(negedge clk);
    a       = addr[AW-1:0];
    full    = (wb_addr_q.size() == DEPTH);
    hit     = 1'b0;
    hit_val = '0;
    for (int i = 0; i < wb_addr_q.size(); i++)
      if (wb_addr_q[i] == a) begin
        hit     = 1'b1;
        hit_val = wb_data_q[i];   // later entries are younger
      end
    exp_stall = wr ? full : (rd && (full || (!FWD && hit)));
    check("stall", {31'b0, mif.MemStall}, {31'b0, exp_stall});
    check("idle",  {31'b0, mif.MemIdle},  {31'b0, (wb_addr_q.size() == 0)});
    ld_acc = rd && !wr && !exp_stall;
    if (ld_acc) begin
      if (FWD && hit) exp_q.push_back('{hit_val, 1'b1});
      else            exp_q.push_back('{ref_mem[a], ref_known[a]});
    end
    ram_read = ld_acc && !(FWD && hit);
    if (wb_addr_q.size() > 0 && !ram_read) begin
      ref_mem[wb_addr_q[0]]   = wb_data_q[0];
      ref_known[wb_addr_q[0]] = 1'b1;
      void'(wb_addr_q.pop_front());
      void'(wb_data_q.pop_front());
    end
    if (wr && !full) begin
      wb_addr_q.push_back(a);
      wb_data_q.push_back(data);
    end
    stalled = exp_stall;
    @(posedge clk);
    #1;
  endtask

  // Issue a request and hold it while stalled, with a cycle budget.
  task automatic req(input bit rd, input bit wr, input logic [DW-1:0] addr,
                     input logic [DW-1:0] data);
    bit st = 1'b1;
    int n  = 0;
    while (st && n < 32) begin
      step(rd, wr, addr, data, st);
      n++;
    end
    if (st) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: still stalled after %0d cycles, addr %h", n, addr);
    end
  endtask

  task automatic idle_cycles(input int n);
    bit st;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, st);
  endtask

  task automatic apply_reset();
    mif.MemRead  = 1'b0;
    mif.MemWrite = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("rst_output", {16'b0, mif.MemOutput}, 32'h0);
    check("rst_stall",  {31'b0, mif.MemStall},  32'h0);
    check("rst_idle",   {31'b0, mif.MemIdle},   32'h1);
    wb_addr_q.delete();
    wb_data_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: consumes one scoreboard entry per accepted load and checks
  // that MemOutput holds between loads.
  initial begin
    logic [DW-1:0] last;
    bit            last_known;
    bit            acc;
    exp_t          e;
    last       = '0;
    last_known = 1'b1;
    forever begin
      @(negedge clk);
      acc = rst_n && mif.MemRead && !mif.MemWrite && !mif.MemStall;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        last       = '0;
        last_known = 1'b1;
      end else begin
        if (acc) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: load accepted with no expected value at %0t", $time);
          end else begin
            e          = exp_q.pop_front();
            last       = e.val;
            last_known = e.known;
          end
        end
        if (last_known) check("mem_output", {16'b0, mif.MemOutput}, {16'b0, last});
      end
    end
  end

  initial begin
    bit            st;
    int            r;
    logic [DW-1:0] ra, rdat;
    for (int i = 0; i < 2**AW; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = 1'b0;
    end
    mif.MemRead  = 1'b0;
    mif.MemWrite = 1'b0;
    mif.MemAddr  = '0;
    mif.MemData  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("init_output", {16'b0, mif.MemOutput}, 32'h0);
    check("init_stall",  {31'b0, mif.MemStall},  32'h0);
    check("init_idle",   {31'b0, mif.MemIdle},   32'h1);
    rst_n = 1'b1;

    // Store then immediate load of the same address.
    req(1'b0, 1'b1, 16'h0004, 16'hFFEB);
    req(1'b1, 1'b0, 16'h0004, '0);
    idle_cycles(3);

    // Youngest of two same-address stores wins.
    req(1'b0, 1'b1, 16'h0007, 16'h1111);
    req(1'b0, 1'b1, 16'h0007, 16'h2222);
    req(1'b1, 1'b0, 16'h0007, '0);
    idle_cycles(3);

    // Back-to-back stores, then read everything back once drained.
    for (int i = 0; i < 5; i++) req(1'b0, 1'b1, DW'(20 + i), DW'(16'hC000 + i));
    idle_cycles(6);
    for (int i = 0; i < 5; i++) req(1'b1, 1'b0, DW'(20 + i), '0);

    // Address wrap.
    req(1'b0, 1'b1, 16'h0105, 16'hABCD);
    req(1'b1, 1'b0, 16'h0005, '0);
    idle_cycles(3);

    // Continuous loads to an unbuffered address with stores pending.
    req(1'b0, 1'b1, 16'h0030, 16'h3030);
    req(1'b0, 1'b1, 16'h0031, 16'h3131);
    for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 16'h0004, '0);
    idle_cycles(4);
    req(1'b1, 1'b0, 16'h0031, '0);

    // Read and write together: store only, output holds.
    req(1'b1, 1'b0, 16'h0004, '0);
    req(1'b1, 1'b1, 16'h0008, 16'h5A5A);
    idle_cycles(3);
    req(1'b1, 1'b0, 16'h0008, '0);

    // Reset with a store still buffered.
    req(1'b0, 1'b1, 16'h0060, 16'h6060);
    apply_reset();
    idle_cycles(2);
    req(1'b1, 1'b0, 16'h0060, '0);
    idle_cycles(2);

    // Randomized traffic over a small address window; stalled requests held.
    for (int n = 0; n < 800; n++) begin
      r    = int'($urandom_range(0, 9));
      ra   = DW'($urandom_range(0, 15)) | DW'($urandom_range(0, 3) << 8);
      rdat = DW'($urandom);
      if (r < 4)      req(1'b0, 1'b1, ra, rdat);
      else if (r < 8) req(1'b1, 1'b0, ra, '0);
      else if (r < 9) req(1'b1, 1'b1, ra, rdat);
      else            idle_cycles(1);
    end
    idle_cycles(8);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d expected loads never seen", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_data_mem_unit
`default_nettype wire
